regfile: RTL and testbench
==========================

# regfile

Architectural integer register file for the 5-stage RISC-V pipeline, and the consumer of the write-back stream produced by the MEM/WB stage register. It holds x0–x31, commits one write per cycle from WB, and serves two combinational read ports to ID with same-cycle write bypass. A per-register pending-write scoreboard tells ID whether an operand is still in flight, so ID can stall instead of reading stale data.

## Interface
- PEND_W, 2: width of each per-register pending-write counter; maximum tracked in-flight writes per register is 2^PEND_W−1.
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  synchronous, active-high reset (`rstEnable).
- rdE_in  input  1  WB write enable.
- rdIdx_in  input  `regIdxRange  WB destination index.
- rdData_in  input  `dataRange  WB write data.
- rs1E_in  input  1  ID read-port-1 enable.
- rs1Idx_in  input  `regIdxRange  read-port-1 index.
- rs2E_in  input  1  ID read-port-2 enable.
- rs2Idx_in  input  `regIdxRange  read-port-2 index.
- issueE_in  input  1  ID hands an instruction with a register destination to EX this cycle.
- issueIdx_in  input  `regIdxRange  destination of the issued instruction.
- rs1Data_out  output  `dataRange  read-port-1 data (combinational).
- rs2Data_out  output  `dataRange  read-port-2 data (combinational).
- rs1Busy_out  output  1  port-1 operand has an uncommitted older write.
- rs2Busy_out  output  1  port-2 operand has an uncommitted older write.

## Operation
- Storage: 32 × 32-bit. x0 is never written; reads of x0 always return `ZERO32.
- Write: on posedge, if rdE_in and rdIdx_in ≠ 0, regs[rdIdx_in] ← rdData_in. rdE_in with rdIdx_in = 0 is a no-op for storage and scoreboard.
- Read port n: rsnE_in low → `ZERO32; rsnIdx_in = 0 → `ZERO32; rdE_in ∧ rdIdx_in = rsnIdx_in ≠ 0 → rdData_in (bypass); else regs[rsnIdx_in].
- Scoreboard: pend[i] per register, i = 1..31; pend[0] is constant 0.
  - inc = issueE_in ∧ issueIdx_in ≠ 0; dec = rdE_in ∧ rdIdx_in ≠ 0.
  - Same index, inc and dec together → unchanged. inc only → +1, saturating at max. dec only → −1, never below 0; dec at 0 is ignored.
  - Issue is asserted only for instructions guaranteed to reach WB; killed instructions are never issued.
- Busy port n: rsnE_in ∧ rsnIdx_in ≠ 0 ∧ effective count ≠ 0, where effective count = pend[idx] − (1 if dec targets idx this cycle). The last pending write committing this cycle is covered by the bypass and does not signal busy. issueE_in in the same cycle does not affect busy: the issuing instruction is younger than its own operands.
- Reset: all regs ← `ZERO32, all pend ← 0. Outputs are combinational from that state, so post-reset reads return `ZERO32 and busy is 0.
- Reset asserted together with a write or issue: reset wins; that write and issue are lost.

## Timing
- Write latency: 1 cycle to storage; 0 cycles to a reader via bypass.
- Read and busy: purely combinational from inputs and state; no registered outputs.
- Scoreboard update: 1 cycle. An issue at cycle t makes busy visible from cycle t+1.
- Critical path: rsIdx → 32:1 mux → bypass mux → ID. The bypass compare must not depend on the array output.

## Structure
- Add to defines.vh: `regNum (32), `pendRange ([PEND_W-1:0] form), and reuse `regIdxRange, `dataRange, `ZERO32, `rstEnable, `writeDisable.
- One sub-module, reg_scoreboard. It holds the pend array, the inc/dec logic, and both busy outputs. The data array and read muxes stay in regfile.

## Test plan
- Reset, then read x5 and x31 on both ports → `ZERO32, busy 0.
- Write x3 = 0xDEADBEEF; next cycle read x3 → 0xDEADBEEF. Write x0 = 0x1234, then read x0 → 0.
- Same-cycle bypass: rdE=1, rdIdx=7, data=0xA5A5A5A5 while rs1Idx=rs2Idx=7 → both outputs 0xA5A5A5A5 in that cycle.
- Issue x9 twice (pend=2), then WB x9 once → rs1Busy still 1. On the second WB cycle, busy 0 and the bypass returns the WB data. Afterwards pend = 0.
- Issue x4 and WB x4 in the same cycle with pend=1 → pend stays 1, busy stays 1 the next cycle. Issuing x0 never sets busy.
- Issue x6 three times, then assert rst_in mid-sequence → next cycle busy 0 and x6 reads 0. Saturation: a 4th issue at PEND_W=2 leaves pend=3.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizes and types for the architectural integer register file.
package regfile_pkg;
  localparam int REG_NUM = 32;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 5;

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam data_t ZERO32 = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters and the two operand-busy flags for ID.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     issueE_in,
  input  reg_idx_t issueIdx_in,
  input  logic     rdE_in,
  input  reg_idx_t rdIdx_in,
  input  logic     rs1E_in,
  input  reg_idx_t rs1Idx_in,
  input  logic     rs2E_in,
  input  reg_idx_t rs2Idx_in,
  output logic     rs1Busy_out,
  output logic     rs2Busy_out
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0]  pend [REG_NUM];
  logic [REG_NUM-1:0] inc_hit;
  logic [REG_NUM-1:0] dec_hit;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    if (issueE_in && issueIdx_in != '0) inc_hit[issueIdx_in] = 1'b1;
    if (rdE_in && rdIdx_in != '0)       dec_hit[rdIdx_in]    = 1'b1;
  end

  // Entry 0 is held at zero so x0 can never look busy.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < REG_NUM; i++) begin
      if (rst_in || i == 0) begin
        pend[i] <= '0;
      end else if (inc_hit[i] && !dec_hit[i] && pend[i] != PEND_MAX) begin
        pend[i] <= pend[i] + PEND_ONE;
      end else if (dec_hit[i] && !inc_hit[i] && pend[i] != '0) begin
        pend[i] <= pend[i] - PEND_ONE;
      end
    end
  end

  // A last pending write that commits this cycle is served by the bypass.
  always_comb begin
    rs1Busy_out = rs1E_in && rs1Idx_in != '0 && pend[rs1Idx_in] != '0 &&
                  !(dec_hit[rs1Idx_in] && pend[rs1Idx_in] == PEND_ONE);
    rs2Busy_out = rs2E_in && rs2Idx_in != '0 && pend[rs2Idx_in] != '0 &&
                  !(dec_hit[rs2Idx_in] && pend[rs2Idx_in] == PEND_ONE);
  end

endmodule

// File: rtl/regfile.sv
// x0-x31 storage with one WB write port, two bypassed combinational read
// ports for ID, and a pending-write scoreboard for operand stalls.
module regfile
  import regfile_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdE_in,
  input  reg_idx_t rdIdx_in,
  input  data_t    rdData_in,
  input  logic     rs1E_in,
  input  reg_idx_t rs1Idx_in,
  input  logic     rs2E_in,
  input  reg_idx_t rs2Idx_in,
  input  logic     issueE_in,
  input  reg_idx_t issueIdx_in,
  output data_t    rs1Data_out,
  output data_t    rs2Data_out,
  output logic     rs1Busy_out,
  output logic     rs2Busy_out
);

  data_t regs [REG_NUM];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= ZERO32;
    end else if (rdE_in && rdIdx_in != '0) begin
      regs[rdIdx_in] <= rdData_in;
    end
  end

  // Bypass select compares indices only, keeping it off the array-mux path.
  always_comb begin
    rs1Data_out = ZERO32;
    rs2Data_out = ZERO32;
    if (rs1E_in && rs1Idx_in != '0)
      rs1Data_out = (rdE_in && rdIdx_in == rs1Idx_in) ? rdData_in : regs[rs1Idx_in];
    if (rs2E_in && rs2Idx_in != '0)
      rs2Data_out = (rdE_in && rdIdx_in == rs2Idx_in) ? rdData_in : regs[rs2Idx_in];
  end

  reg_scoreboard #(.PEND_W(PEND_W)) u_scoreboard (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .issueE_in   (issueE_in),
    .issueIdx_in (issueIdx_in),
    .rdE_in      (rdE_in),
    .rdIdx_in    (rdIdx_in),
    .rs1E_in     (rs1E_in),
    .rs1Idx_in   (rs1Idx_in),
    .rs2E_in     (rs2E_in),
    .rs2Idx_in   (rs2Idx_in),
    .rs1Busy_out (rs1Busy_out),
    .rs2Busy_out (rs2Busy_out)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: reference model feeds an expected queue.
module tb_regfile;
  localparam int PEND_W   = 2;
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic        clk_in;
  logic        rst_in;
  logic        rdE_in;
  logic [4:0]  rdIdx_in;
  logic [31:0] rdData_in;
  logic        rs1E_in;
  logic [4:0]  rs1Idx_in;
  logic        rs2E_in;
  logic [4:0]  rs2Idx_in;
  logic        issueE_in;
  logic [4:0]  issueIdx_in;
  logic [31:0] rs1Data_out;
  logic [31:0] rs2Data_out;
  logic        rs1Busy_out;
  logic        rs2Busy_out;

  int tests_run;
  int tests_failed;

  logic [31:0] m_regs [32];
  int          m_pend [32];
  logic [65:0] exp_q [$];

  regfile #(.PEND_W(PEND_W)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdE_in      (rdE_in),
    .rdIdx_in    (rdIdx_in),
    .rdData_in   (rdData_in),
    .rs1E_in     (rs1E_in),
    .rs1Idx_in   (rs1Idx_in),
    .rs2E_in     (rs2E_in),
    .rs2Idx_in   (rs2Idx_in),
    .issueE_in   (issueE_in),
    .issueIdx_in (issueIdx_in),
    .rs1Data_out (rs1Data_out),
    .rs2Data_out (rs2Data_out),
    .rs1Busy_out (rs1Busy_out),
    .rs2Busy_out (rs2Busy_out)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic e, input logic [4:0] idx);
    if (!e || idx == 0) return 32'h0;
    if (rdE_in && rdIdx_in == idx) return rdData_in;
    return m_regs[idx];
  endfunction

  function automatic logic model_busy(input logic e, input logic [4:0] idx);
    int eff;
    if (!e || idx == 0) return 1'b0;
    eff = m_pend[idx];
    if (rdE_in && rdIdx_in == idx && eff > 0) eff--;
    return eff != 0;
  endfunction

  // driver: apply one cycle of inputs and queue the expected outputs
  task automatic set_in(input logic rst, input logic rde, input logic [4:0] rdi,
                        input logic [31:0] rdd, input logic e1, input logic [4:0] i1,
                        input logic e2, input logic [4:0] i2,
                        input logic ise, input logic [4:0] isi);
    rst_in = rst; rdE_in = rde; rdIdx_in = rdi; rdData_in = rdd;
    rs1E_in = e1; rs1Idx_in = i1; rs2E_in = e2; rs2Idx_in = i2;
    issueE_in = ise; issueIdx_in = isi;
    exp_q.push_back({model_busy(e1, i1), model_busy(e2, i2), model_read(e1, i1), model_read(e2, i2)});
  endtask

  // scoreboard compare, then clock edge and model update
  task automatic cycle();
    logic [65:0] e;
    logic        inc, dec;
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("rs1_busy", {31'd0, rs1Busy_out}, {31'd0, e[65]});
      check("rs2_busy", {31'd0, rs2Busy_out}, {31'd0, e[64]});
      check("rs1_data", rs1Data_out, e[63:32]);
      check("rs2_data", rs2Data_out, e[31:0]);
    end
    @(posedge clk_in);
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_pend[i] = 0;
      end
    end else begin
      if (rdE_in && rdIdx_in != 0) m_regs[rdIdx_in] = rdData_in;
      inc = issueE_in && issueIdx_in != 0;
      dec = rdE_in && rdIdx_in != 0;
      if (!(inc && dec && issueIdx_in == rdIdx_in)) begin
        if (inc && m_pend[issueIdx_in] < PEND_MAX) m_pend[issueIdx_in]++;
        if (dec && m_pend[rdIdx_in] > 0) m_pend[rdIdx_in]--;
      end
    end
    @(negedge clk_in);
  endtask

  task automatic idle_read(input logic [4:0] i1, input logic [4:0] i2);
    set_in(0, 0, 0, 0, 1, i1, 1, i2, 0, 0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 0;
    end
    rst_in = 1; rdE_in = 0; rdIdx_in = 0; rdData_in = 0;
    rs1E_in = 0; rs1Idx_in = 0; rs2E_in = 0; rs2Idx_in = 0;
    issueE_in = 0; issueIdx_in = 0;
    @(negedge clk_in);
    repeat (2) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end

    // post-reset reads
    idle_read(5, 31);
    #1; check("rst_x5", rs1Data_out, 32'h0); check("rst_x31", rs2Data_out, 32'h0);
    check("rst_busy", {30'd0, rs1Busy_out, rs2Busy_out}, 32'd0);
    cycle();
    idle_read(31, 5); cycle();

    // write then read, and x0 write ignored
    set_in(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0); cycle();
    idle_read(3, 3);
    #1; check("x3_read", rs1Data_out, 32'hDEADBEEF);
    cycle();
    set_in(0, 1, 0, 32'h1234, 1, 0, 0, 0, 0, 0); cycle();
    idle_read(0, 0);
    #1; check("x0_read", rs1Data_out, 32'h0);
    cycle();

    // same-cycle bypass on both ports
    set_in(0, 1, 7, 32'hA5A5A5A5, 1, 7, 1, 7, 0, 0);
    #1; check("byp_rs1", rs1Data_out, 32'hA5A5A5A5); check("byp_rs2", rs2Data_out, 32'hA5A5A5A5);
    cycle();
    idle_read(7, 3); cycle();

    // two in-flight writes to x9
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 9); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 9); cycle();
    set_in(0, 1, 9, 32'h11111111, 1, 9, 0, 0, 0, 0);
    #1; check("x9_busy_first_wb", {31'd0, rs1Busy_out}, 32'd1);
    cycle();
    set_in(0, 1, 9, 32'h22222222, 1, 9, 1, 9, 0, 0);
    #1; check("x9_busy_last_wb", {31'd0, rs1Busy_out}, 32'd0);
    check("x9_last_byp", rs1Data_out, 32'h22222222);
    cycle();
    idle_read(9, 9);
    #1; check("x9_idle", {31'd0, rs1Busy_out}, 32'd0);
    cycle();

    // issue and WB of x4 in the same cycle, and issue of x0
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 4); cycle();
    set_in(0, 1, 4, 32'h44444444, 1, 4, 0, 0, 1, 4); cycle();
    set_in(0, 0, 0, 0, 1, 4, 1, 0, 1, 0);
    #1; check("x4_still_busy", {31'd0, rs1Busy_out}, 32'd1);
    cycle();
    idle_read(0, 4);
    #1; check("x0_never_busy", {31'd0, rs1Busy_out}, 32'd0);
    cycle();
    set_in(0, 1, 4, 32'h55555555, 1, 4, 0, 0, 0, 0); cycle();

    // saturation: four issues of x6 leave three pending
    repeat (4) begin set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 6); cycle(); end
    set_in(0, 1, 6, 32'h66666666, 1, 6, 0, 0, 0, 0);
    #1; check("sat_wb1_busy", {31'd0, rs1Busy_out}, 32'd1);
    cycle();
    set_in(0, 1, 6, 32'h66666666, 1, 6, 0, 0, 0, 0); cycle();
    set_in(0, 1, 6, 32'h66666666, 1, 6, 0, 0, 0, 0);
    #1; check("sat_wb3_busy", {31'd0, rs1Busy_out}, 32'd0);
    cycle();

    // reset wins over pending issues and a concurrent write
    repeat (3) begin set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 6); cycle(); end
    set_in(1, 1, 6, 32'h77777777, 1, 6, 0, 0, 1, 6); cycle();
    idle_read(6, 6);
    #1; check("rst_x6_busy", {31'd0, rs1Busy_out}, 32'd0); check("rst_x6_data", rs1Data_out, 32'h0);
    cycle();

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      set_in($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             $urandom, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
